bp_stall_histogram: RTL and testbench
=====================================

Name: bp_stall_histogram

Overview:
- Synthesizable, parametrised stall-attribution and histogram unit for one BlackParrot core.
- Carries per-stage stall-reason bit vectors down a configurable-depth attribution pipeline. Each non-retiring cycle is priority-encoded to a single reason, and a per-reason saturating counter is bumped.
- Counters are readable through a registered read port, with atomic snapshot and synchronous clear.
- Sits beside the core and replaces simulation-only stall histograms, so counts are available on FPGA through the host CSR path.

Parameters:
- num_reasons_p, 31, number of stall-reason bits; bit 0 is "unknown".
- num_stages_p, 7, attribution pipeline depth (IF0..EX3).
- cnt_width_p, 32, width of every counter.
- freeze_delay_p, 8, cycles freeze_i is delayed before gating counting (at least 1).
- lg_addr_lp, clog2(num_reasons_p+2), read address width (local).

Ports:
- clk_i  in  1  clock
- reset_li  in  1  reset, asynchronous, active-low
- freeze_i  in  1  core freeze; counting disabled while delayed copy is high
- inject_i  in  num_stages_p*num_reasons_p  per-stage reason OR-masks; slice k belongs to stage k
- pass_i  in  num_stages_p  pass_i[k]=1 lets stage k inherit stage k-1 register; pass_i[0] ignored
- instret_i  in  1  an instruction retired this cycle
- clear_i  in  1  synchronous clear of all live counters
- snapshot_i  in  1  copy all live counters into shadow bank
- rd_v_i  in  1  read request
- rd_addr_i  in  lg_addr_lp  0..num_reasons_p-1 reason counters; num_reasons_p instret counter; num_reasons_p+1 cycle counter
- rd_shadow_i  in  1  read from shadow bank instead of live
- rd_v_o  out  1  read data valid
- rd_data_o  out  cnt_width_p  read data
- stall_v_o  out  1  this cycle counted as a stall
- stall_reason_o  out  clog2(num_reasons_p)  encoded reason this cycle

Behaviour:
- Reset (reset_li=0, async):
  - stage registers, live and shadow counters, rd_v_o, rd_data_o all clear to 0.
  - Freeze delay chain sets to all-ones, so counting starts only freeze_delay_p cycles after freeze_i is first seen low.
- Attribution pipeline:
  - stage_n[0] = inject[0].
  - stage_n[k] = (pass_i[k] ? stage_r[k-1] : 0) | inject[k], for k in 1..num_stages_p-1.
  - stage_r <= stage_n every cycle.
  - Attributed vector is stage_n[num_stages_p-1], combinational in the current cycle. An inject at stage 0 in cycle t is therefore attributed in cycle t+num_stages_p-1 if every pass is high.
- Encode: the lowest set bit index wins. If the vector is all-zero, the reason is 0 (unknown).
- en = ~freeze_d, where freeze_d is freeze_i delayed freeze_delay_p cycles.
- When en=1, on each cycle:
  - cycle counter +1.
  - If instret_i, instret counter +1.
  - Otherwise counter[reason] +1.
  - stall_v_o = en & ~instret_i. stall_reason_o is valid only when stall_v_o=1 and is combinational.
- Saturation: every counter holds at 2^cnt_width_p-1 and never wraps.
- clear_i zeroes all live counters the next cycle. A concurrent increment is dropped, so the result is 0. The shadow bank is unaffected.
- snapshot_i copies live values as they stand before this cycle's update.
- Snapshot and clear in the same cycle: the shadow receives the pre-clear values and live becomes 0. This is the read-and-reset idiom.
- Read port:
  - rd_v_i in cycle t gives rd_v_o=1 and rd_data_o in cycle t+1; one request per cycle, fully pipelined, no backpressure.
  - A live read returns the value before that cycle's update.
  - Out-of-range address (above num_reasons_p+1) returns 0 with rd_v_o=1.
  - rd_data_o holds its last value when rd_v_o=0.
- freeze_i toggling mid-run only gates counting; pipeline contents keep flowing.
- Reset mid-operation: everything returns to reset state immediately.

Test Plan:
- Reset, freeze_i=0, no injects, instret_i=0: nothing counts for cycles 0..7. From cycle 8 the unknown counter and cycle counter increment each cycle. After 20 cycles, read addr 0 gives 12 and addr num_reasons_p+1 gives 12.
- Pulse inject stage0 bit 30 for one cycle with all pass high: stall_reason_o=30 exactly 6 cycles later and reason-30 counter=1. Repeat with pass_i[3]=0 at the right cycle: the bit is squashed and the unknown counter gets the cycle.
- Inject bits 5 and 12 simultaneously in stage 6: reason 5 counted and counter[12] stays 0.
- With cnt_width_p=4, hold stall reason 3 for 20 cycles: counter[3] reads 15.
- After 10 counted cycles of reason 2, assert snapshot_i and clear_i together. Shadow read addr 2 gives 10, live read gives 0; the next counted cycle gives live 1.
- Alternate instret_i=1/0 for 10 enabled cycles: instret counter 5, cycle counter 10, reason counters summing to 5.

Source files
------------

// File: rtl/bp_stall_histogram.sv
// Stall attribution and histogram unit: carries per-stage stall-reason vectors down a
// pass-gated pipeline, encodes one reason per non-retiring cycle and keeps saturating counts.
module bp_stall_histogram #(
    parameter int num_reasons_p  = 31,
    parameter int num_stages_p   = 7,
    parameter int cnt_width_p    = 32,
    parameter int freeze_delay_p = 8,
    localparam int lg_addr_lp    = $clog2(num_reasons_p + 2),
    localparam int lg_reason_lp  = $clog2(num_reasons_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_li,
    input  logic                                    freeze_i,
    input  logic [num_stages_p*num_reasons_p-1:0]   inject_i,
    input  logic [num_stages_p-1:0]                 pass_i,
    input  logic                                    instret_i,
    input  logic                                    clear_i,
    input  logic                                    snapshot_i,
    input  logic                                    rd_v_i,
    input  logic [lg_addr_lp-1:0]                   rd_addr_i,
    input  logic                                    rd_shadow_i,
    output logic                                    rd_v_o,
    output logic [cnt_width_p-1:0]                  rd_data_o,
    output logic                                    stall_v_o,
    output logic [lg_reason_lp-1:0]                 stall_reason_o
);

    localparam logic [lg_addr_lp-1:0] instret_addr_lp = lg_addr_lp'(num_reasons_p);
    localparam logic [lg_addr_lp-1:0] cycle_addr_lp   = lg_addr_lp'(num_reasons_p + 1);

    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (v == '1) ? v : v + cnt_width_p'(1);
    endfunction

    // Freeze delay line; preset to ones so counting waits for a full delay after reset.
    logic [freeze_delay_p-1:0] freeze_chain_r;
    logic                      en;

    generate
        if (freeze_delay_p == 1) begin : g_freeze_one
            always_ff @(posedge clk_i or negedge reset_li) begin
                if (!reset_li) freeze_chain_r <= '1;
                else           freeze_chain_r <= freeze_i;
            end
        end else begin : g_freeze_many
            always_ff @(posedge clk_i or negedge reset_li) begin
                if (!reset_li) freeze_chain_r <= '1;
                else           freeze_chain_r <= {freeze_chain_r[freeze_delay_p-2:0], freeze_i};
            end
        end
    endgenerate

    assign en = ~freeze_chain_r[freeze_delay_p-1];

    // Only stages 0..n-2 need storage; the last stage is consumed combinationally.
    logic [num_reasons_p-1:0] stage_r [num_stages_p-1];
    logic [num_reasons_p-1:0] stage_n [num_stages_p];
    logic                     unused_pass0;

    assign unused_pass0 = pass_i[0];

    always_comb begin
        stage_n[0] = inject_i[0 +: num_reasons_p];
        for (int k = 1; k < num_stages_p; k++) begin
            stage_n[k] = (pass_i[k] ? stage_r[k-1] : '0) | inject_i[k*num_reasons_p +: num_reasons_p];
        end
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int k = 0; k < num_stages_p - 1; k++) stage_r[k] <= '0;
        end else begin
            for (int k = 0; k < num_stages_p - 1; k++) stage_r[k] <= stage_n[k];
        end
    end

    logic [num_reasons_p-1:0] attr_vec;
    logic [lg_reason_lp-1:0]  reason;

    assign attr_vec = stage_n[num_stages_p-1];

    always_comb begin
        reason = '0;
        for (int i = num_reasons_p - 1; i >= 0; i--) begin
            if (attr_vec[i]) reason = lg_reason_lp'(i);
        end
    end

    assign stall_v_o      = en & ~instret_i;
    assign stall_reason_o = reason;

    logic [cnt_width_p-1:0] reason_cnt_r  [num_reasons_p];
    logic [cnt_width_p-1:0] reason_shad_r [num_reasons_p];
    logic [cnt_width_p-1:0] instret_cnt_r, cycle_cnt_r;
    logic [cnt_width_p-1:0] instret_shad_r, cycle_shad_r;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int i = 0; i < num_reasons_p; i++) reason_cnt_r[i] <= '0;
            instret_cnt_r <= '0;
            cycle_cnt_r   <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < num_reasons_p; i++) reason_cnt_r[i] <= '0;
            instret_cnt_r <= '0;
            cycle_cnt_r   <= '0;
        end else if (en) begin
            cycle_cnt_r <= sat_inc(cycle_cnt_r);
            if (instret_i) instret_cnt_r <= sat_inc(instret_cnt_r);
            else           reason_cnt_r[reason] <= sat_inc(reason_cnt_r[reason]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            for (int i = 0; i < num_reasons_p; i++) reason_shad_r[i] <= '0;
            instret_shad_r <= '0;
            cycle_shad_r   <= '0;
        end else if (snapshot_i) begin
            for (int i = 0; i < num_reasons_p; i++) reason_shad_r[i] <= reason_cnt_r[i];
            instret_shad_r <= instret_cnt_r;
            cycle_shad_r   <= cycle_cnt_r;
        end
    end

    // Read port: rd_v_i in cycle t yields rd_v_o/rd_data_o in t+1, one request per
    // cycle, no backpressure; rd_data_o holds its last value while rd_v_o is low.
    logic [cnt_width_p-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (rd_addr_i < instret_addr_lp) begin
            rd_mux = rd_shadow_i ? reason_shad_r[rd_addr_i[lg_reason_lp-1:0]]
                                 : reason_cnt_r[rd_addr_i[lg_reason_lp-1:0]];
        end else if (rd_addr_i == instret_addr_lp) begin
            rd_mux = rd_shadow_i ? instret_shad_r : instret_cnt_r;
        end else if (rd_addr_i == cycle_addr_lp) begin
            rd_mux = rd_shadow_i ? cycle_shad_r : cycle_cnt_r;
        end
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            rd_v_o    <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_v_o <= rd_v_i;
            if (rd_v_i) rd_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Randomized bench for bp_stall_histogram: a full-width and a 4-bit-counter instance share
// stimulus and are compared against a path-based behavioural model of attribution and counting.
module tb_bp_stall_histogram;

    localparam int NR = 31;
    localparam int S  = 7;
    localparam int D  = 8;
    localparam int LA = $clog2(NR + 2);
    localparam int LR = $clog2(NR);
    localparam int HQ = 16;

    logic clk;
    logic reset_li;
    logic freeze, instret, clear, snapshot, rd_v, rd_shadow;
    logic [S*NR-1:0] inject;
    logic [S-1:0]    pass;
    logic [LA-1:0]   rd_addr;

    logic          rd_v_o, stall_v_o;
    logic [31:0]   rd_data_o;
    logic [LR-1:0] stall_reason_o;
    logic          rd_v_s, stall_v_s;
    logic [3:0]    rd_data_s;
    logic [LR-1:0] reason_s;

    bp_stall_histogram #(.num_reasons_p(NR), .num_stages_p(S), .cnt_width_p(32), .freeze_delay_p(D)) dut (
        .clk_i(clk), .reset_li(reset_li), .freeze_i(freeze), .inject_i(inject), .pass_i(pass),
        .instret_i(instret), .clear_i(clear), .snapshot_i(snapshot), .rd_v_i(rd_v),
        .rd_addr_i(rd_addr), .rd_shadow_i(rd_shadow), .rd_v_o(rd_v_o), .rd_data_o(rd_data_o),
        .stall_v_o(stall_v_o), .stall_reason_o(stall_reason_o));

    bp_stall_histogram #(.num_reasons_p(NR), .num_stages_p(S), .cnt_width_p(4), .freeze_delay_p(D)) dut_sat (
        .clk_i(clk), .reset_li(reset_li), .freeze_i(freeze), .inject_i(inject), .pass_i(pass),
        .instret_i(instret), .clear_i(clear), .snapshot_i(snapshot), .rd_v_i(rd_v),
        .rd_addr_i(rd_addr), .rd_shadow_i(rd_shadow), .rd_v_o(rd_v_s), .rd_data_o(rd_data_s),
        .stall_v_o(stall_v_s), .stall_reason_o(reason_s));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [S*NR-1:0] inj;
        logic [S-1:0]    pas;
        logic            frz;
    } hist_t;

    hist_t       h_q[$];
    longint      live_m [NR+2];
    longint      shad_m [NR+2];
    logic [31:0] exp_q[$];
    logic [31:0] exp_sat_q[$];
    logic [31:0] last_d, last_s;
    int          n_cmp, n_bad;

    logic            nx_freeze, nx_instret, nx_clear, nx_snapshot, nx_rd_v, nx_rd_shadow;
    logic [S*NR-1:0] nx_inject;
    logic [S-1:0]    nx_pass;
    logic [LA-1:0]   nx_rd_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (64'sd1 <<< w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Attributed vector: an inject at stage k survives to the last stage only if every
    // downstream pass along its path was high in the cycle it crossed that boundary.
    function automatic logic [NR-1:0] model_vec();
        logic [NR-1:0] v;
        logic          ok;
        v = '0;
        for (int k = 0; k < S; k++) begin
            if (S - 1 - k < h_q.size()) begin
                ok = 1'b1;
                for (int j = k + 1; j < S; j++) begin
                    if (!h_q[S-1-j].pas[j]) ok = 1'b0;
                end
                if (ok) v |= h_q[S-1-k].inj[k*NR +: NR];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int addr, input logic shadow, input int w);
        if (addr >= NR + 2) return 32'd0;
        return 32'(sat(shadow ? shad_m[addr] : live_m[addr], w));
    endfunction

    task automatic model_reset();
        h_q.delete();
        exp_q.delete();
        exp_sat_q.delete();
        for (int i = 0; i < NR + 2; i++) begin
            live_m[i] = 0;
            shad_m[i] = 0;
        end
        last_d = '0;
        last_s = '0;
    endtask

    task automatic model_cycle();
        hist_t         h;
        logic [NR-1:0] vec;
        int            rsn;
        logic          en, exp_stall;
        h.inj = inject;
        h.pas = pass;
        h.frz = freeze;
        h_q.push_front(h);
        if (h_q.size() > HQ) void'(h_q.pop_back());
        vec = model_vec();
        rsn = 0;
        for (int i = 0; i < NR; i++) begin
            if (vec[i]) begin
                rsn = i;
                break;
            end
        end
        en = (h_q.size() > D) ? !h_q[D].frz : 1'b0;
        exp_stall = en && !instret;
        check_val("stall_v", 64'(stall_v_o), 64'(exp_stall));
        check_val("stall_v_sat", 64'(stall_v_s), 64'(exp_stall));
        if (exp_stall) begin
            check_val("stall_reason", 64'(stall_reason_o), 64'(rsn));
            check_val("stall_reason_sat", 64'(reason_s), 64'(rsn));
        end
        if (rd_v) begin
            exp_q.push_back(model_read(int'(rd_addr), rd_shadow, 32));
            exp_sat_q.push_back(model_read(int'(rd_addr), rd_shadow, 4));
        end
        if (snapshot) shad_m = live_m;
        if (clear) begin
            for (int i = 0; i < NR + 2; i++) live_m[i] = 0;
        end else if (en) begin
            live_m[NR+1]++;
            if (instret) live_m[NR]++;
            else         live_m[rsn]++;
        end
    endtask

    task automatic check_rd();
        check_val("rd_v", 64'(rd_v_o), 64'(exp_q.size() != 0));
        check_val("rd_v_sat", 64'(rd_v_s), 64'(exp_sat_q.size() != 0));
        if (exp_q.size() != 0) begin
            last_d = exp_q.pop_front();
            last_s = exp_sat_q.pop_front();
        end
        check_val("rd_data", 64'(rd_data_o), 64'(last_d));
        check_val("rd_data_sat", 64'(rd_data_s), 64'(last_s));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        check_rd();
        freeze    = nx_freeze;
        inject    = nx_inject;
        pass      = nx_pass;
        instret   = nx_instret;
        clear     = nx_clear;
        snapshot  = nx_snapshot;
        rd_v      = nx_rd_v;
        rd_addr   = nx_rd_addr;
        rd_shadow = nx_rd_shadow;
        #1 model_cycle();
        nx_inject   = '0;
        nx_clear    = 1'b0;
        nx_snapshot = 1'b0;
        nx_rd_v     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input int addr, input logic shadow);
        nx_rd_v      = 1'b1;
        nx_rd_addr   = LA'(addr);
        nx_rd_shadow = shadow;
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_rd();
        reset_li = 1'b0;
        rd_v = 1'b0; clear = 1'b0; snapshot = 1'b0; inject = '0;
        #1;
        check_val("rst_rd_v", 64'(rd_v_o), 64'd0);
        check_val("rst_rd_data", 64'(rd_data_o), 64'd0);
        check_val("rst_stall_v", 64'(stall_v_o), 64'd0);
        check_val("rst_rd_data_sat", 64'(rd_data_s), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset_li = 1'b1;
    endtask

    task automatic hold_reason(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            nx_inject[(S-1)*NR + r] = 1'b1;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_bad = 0;
        reset_li = 1'b1;
        freeze = 1'b0; instret = 1'b0; clear = 1'b0; snapshot = 1'b0;
        rd_v = 1'b0; rd_shadow = 1'b0; rd_addr = '0; inject = '0; pass = '1;
        nx_freeze = 1'b0; nx_instret = 1'b0; nx_clear = 1'b0; nx_snapshot = 1'b0;
        nx_rd_v = 1'b0; nx_rd_shadow = 1'b0; nx_rd_addr = '0; nx_inject = '0; nx_pass = '1;
        model_reset();
        do_reset();

        // freeze delay after reset, then unknown-reason counting
        idle(20);
        rd(0, 1'b0);
        rd(NR + 1, 1'b0);

        // single inject at stage 0 flows through; then squashed at stage 3
        nx_inject[30] = 1'b1;
        tick();
        idle(8);
        rd(30, 1'b0);
        nx_inject[30] = 1'b1;
        tick();
        idle(2);
        nx_pass[3] = 1'b0;
        tick();
        nx_pass = '1;
        idle(6);
        rd(30, 1'b0);
        rd(0, 1'b0);

        // two simultaneous reasons at the last stage: lowest wins
        nx_inject[(S-1)*NR + 5]  = 1'b1;
        nx_inject[(S-1)*NR + 12] = 1'b1;
        tick();
        rd(5, 1'b0);
        rd(12, 1'b0);

        // saturation on the 4-bit instance
        nx_clear = 1'b1;
        tick();
        hold_reason(3, 20);
        rd(3, 1'b0);

        // snapshot + clear together
        nx_clear = 1'b1;
        tick();
        hold_reason(2, 10);
        nx_snapshot = 1'b1;
        nx_clear    = 1'b1;
        hold_reason(2, 1);
        rd(2, 1'b1);
        rd(2, 1'b0);
        hold_reason(2, 1);
        rd(2, 1'b0);

        // alternating retirement
        nx_clear = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            nx_instret = (i % 2 == 0);
            tick();
        end
        nx_instret = 1'b0;
        rd(NR, 1'b0);
        rd(NR + 1, 1'b0);
        rd(0, 1'b0);
        rd(50, 1'b0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) nx_freeze = ~nx_freeze;
            for (int k = 0; k < S; k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    nx_inject[k*NR + $urandom_range(0, NR-1)] = 1'b1;
                    if ($urandom_range(0, 3) == 0) nx_inject[k*NR + $urandom_range(0, NR-1)] = 1'b1;
                end
                nx_pass[k] = ($urandom_range(0, 7) != 0);
            end
            nx_instret   = $urandom_range(0, 1) == 1;
            nx_clear     = $urandom_range(0, 59) == 0;
            nx_snapshot  = $urandom_range(0, 29) == 0;
            nx_rd_v      = $urandom_range(0, 1) == 1;
            nx_rd_addr   = LA'($urandom_range(0, (1 << LA) - 1));
            nx_rd_shadow = $urandom_range(0, 1) == 1;
            tick();
        end
        nx_freeze = 1'b0; nx_pass = '1; nx_instret = 1'b0;
        for (int a = 0; a < NR + 2; a++) rd(a, 1'b0);
        for (int a = 0; a < NR + 2; a++) rd(a, 1'b1);

        // reset in the middle of operation
        rd(NR + 1, 1'b0);
        do_reset();
        idle(12);
        rd(0, 1'b0);
        rd(NR + 1, 1'b1);
        rd(40, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
